// File: rtl/aib_link_bringup_ctrl.sv
// aib_link_bringup_ctrl: leader-side AIB link bring-up sequencer (config writes, reset release, lock, align, bounded retry)
module aib_link_bringup_ctrl #(
  parameter int NBR_CHNLS    = 24,
  parameter int ACTIVE_CHNLS = 24,
  parameter int AVMM_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 4,
  parameter int CFG_WORDS    = 4,
  parameter int TIMEOUT      = 65535,
  parameter int RST_HOLD     = 16,
  parameter int RETRY_MAX    = 3
) (
  input  logic                            i_cfg_avmm_clk,
  input  logic                            i_cfg_avmm_rst,
  input  logic                            enable,
  input  logic [CFG_WORDS*17-1:0]         cfg_addr_tbl,
  input  logic [CFG_WORDS*AVMM_WIDTH-1:0] cfg_data_tbl,
  output logic [16:0]                     o_cfg_avmm_addr,
  output logic [AVMM_WIDTH-1:0]           o_cfg_avmm_wdata,
  output logic [BYTE_WIDTH-1:0]           o_cfg_avmm_byte_en,
  output logic                            o_cfg_avmm_write,
  input  logic                            i_cfg_avmm_waitreq,
  input  logic                            m_device_detect,
  input  logic [NBR_CHNLS-1:0]            fs_mac_rdy,
  input  logic [NBR_CHNLS-1:0]            m_rx_align_done,
  output logic [NBR_CHNLS-1:0]            ns_adapter_rstn,
  output logic [NBR_CHNLS-1:0]            ns_mac_rdy,
  output logic [NBR_CHNLS-1:0]            ms_rx_dcc_dll_lock_req,
  output logic [NBR_CHNLS-1:0]            ms_tx_dcc_dll_lock_req,
  output logic                            link_up,
  output logic                            link_err,
  output logic [1:0]                      retry_cnt,
  output logic [3:0]                      state
);
  localparam int IW = CFG_WORDS > 1 ? $clog2(CFG_WORDS) : 1;
  localparam logic [NBR_CHNLS-1:0] ACT_MASK = {NBR_CHNLS{1'b1}} >> (NBR_CHNLS - ACTIVE_CHNLS);
  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_WAIT_DET, S_CFG, S_REL, S_WAIT_FS,
    S_LOCK, S_WAIT_ALN, S_LINK_UP, S_FAIL, S_ERROR
  } state_t;
  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [1:0]              retry_q, retry_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [16:0]             addr_q, addr_d;
  logic [AVMM_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BYTE_WIDTH-1:0]   be_q, be_d;
  logic                    wr_q, wr_d;
  logic [NBR_CHNLS-1:0]    rstn_q, rstn_d, mrdy_q, mrdy_d, lock_q, lock_d;
  logic                    up_q, up_d, err_q, err_d;
  logic                    fs_ok, aln_ok, tmo, rel, lck;
  always_comb begin
    fs_ok   = &(fs_mac_rdy | ~ACT_MASK);
    aln_ok  = &(m_rx_align_done | ~ACT_MASK);
    tmo     = cnt_q == 16'(TIMEOUT - 1);
    state_d = state_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE:     state_d = S_RST;
        S_RST:      state_d = cnt_q == 16'(RST_HOLD - 1) ? S_WAIT_DET : S_RST;
        S_WAIT_DET: state_d = m_device_detect ? S_CFG : tmo ? S_FAIL : S_WAIT_DET;
        S_CFG: if (!i_cfg_avmm_waitreq) begin
          if (idx_q == IW'(CFG_WORDS - 1)) state_d = S_REL;
          else idx_d = idx_q + 1'b1;
        end
        S_REL:      state_d = S_WAIT_FS;
        S_WAIT_FS:  state_d = fs_ok ? S_LOCK : tmo ? S_FAIL : S_WAIT_FS;
        S_LOCK:     state_d = S_WAIT_ALN;
        S_WAIT_ALN: state_d = aln_ok ? S_LINK_UP : tmo ? S_FAIL : S_WAIT_ALN;
        S_LINK_UP: if (!(fs_ok && aln_ok)) begin
          state_d = S_RST;
          retry_d = '0;
        end
        S_FAIL: if (retry_q < 2'(RETRY_MAX)) begin
          retry_d = retry_q + 2'd1;
          state_d = S_RST;
        end else state_d = S_ERROR;
        S_ERROR:    state_d = S_ERROR;
        default:    state_d = S_IDLE;
      endcase
    end
    if (state_d != S_CFG) idx_d = '0;
    cnt_d   = state_d != state_q ? '0 : cnt_q + 1'b1;
    wr_d    = state_d == S_CFG;
    addr_d  = wr_d ? cfg_addr_tbl[int'(idx_d)*17 +: 17] : '0;
    wdata_d = wr_d ? cfg_data_tbl[int'(idx_d)*AVMM_WIDTH +: AVMM_WIDTH] : '0;
    be_d    = {BYTE_WIDTH{wr_d}};
    rel     = state_d inside {S_REL, S_WAIT_FS, S_LOCK, S_WAIT_ALN, S_LINK_UP};
    lck     = state_d inside {S_LOCK, S_WAIT_ALN, S_LINK_UP};
    rstn_d  = rel ? ACT_MASK : '0;
    mrdy_d  = rel ? ACT_MASK : '0;
    lock_d  = lck ? ACT_MASK : '0;
    up_d    = state_d == S_LINK_UP;
    err_d   = state_d == S_ERROR;
  end
  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      rstn_q  <= '0;
      mrdy_q  <= '0;
      lock_q  <= '0;
      up_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      rstn_q  <= rstn_d;
      mrdy_q  <= mrdy_d;
      lock_q  <= lock_d;
      up_q    <= up_d;
      err_q   <= err_d;
    end
  end
  assign o_cfg_avmm_addr        = addr_q;
  assign o_cfg_avmm_wdata       = wdata_q;
  assign o_cfg_avmm_byte_en     = be_q;
  assign o_cfg_avmm_write       = wr_q;
  assign ns_adapter_rstn        = rstn_q;
  assign ns_mac_rdy             = mrdy_q;
  assign ms_rx_dcc_dll_lock_req = lock_q;
  assign ms_tx_dcc_dll_lock_req = lock_q;
  assign link_up                = up_q;
  assign link_err               = err_q;
  assign retry_cnt              = retry_q;
  assign state                  = state_q;
endmodule
